// File: rtl/mem_arb2_pkg.sv
// Shared memory-interface types and widths for the two-port arbiter.
package mem_intf_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S0   = 2'd1,
    OWN_S1   = 2'd2
  } mem_own_e;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_BW = 4;

endpackage

// File: rtl/rr_arb2.sv
// Round-robin pointer and tie-break for two requesters.
// The pointer remembers the last requester that completed a transfer;
// on a tie the other one wins.
module rr_arb2
  import mem_intf_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     req0_i,
  input  logic     req1_i,
  input  logic     upd_i,
  input  mem_own_e upd_own_i,
  output mem_own_e pick_o
);

  // 0 = S0 served last, 1 = S1 served last
  logic last_q;

  // Pick a requester from the current requests only, breaking ties away from last_q
  always_comb begin
    pick_o = OWN_NONE;
    if (req0_i && req1_i) begin
      pick_o = last_q ? OWN_S0 : OWN_S1;
    end else if (req0_i) begin
      pick_o = OWN_S0;
    end else if (req1_i) begin
      pick_o = OWN_S1;
    end
  end

  // Move the pointer to whoever just completed a transfer; S1 at reset so S0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (upd_i && upd_own_i != OWN_NONE) begin
      last_q <= (upd_own_i == OWN_S1);
    end
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester arbiter for one synchronous memory port.
// Grant is combinational from registered state, so a lone request reaches
// the memory port in the same cycle; read data is routed back one cycle
// after the accept only to the requester that issued it.
module mem_arb2
  import mem_intf_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_cs,
  input  logic              s0_we,
  input  logic [MEM_AW-1:0] s0_addr,
  input  logic [MEM_BW-1:0] s0_byte,
  input  logic [MEM_DW-1:0] s0_di,
  output logic [MEM_DW-1:0] s0_do,
  output logic              s0_busy,
  input  logic              s1_cs,
  input  logic              s1_we,
  input  logic [MEM_AW-1:0] s1_addr,
  input  logic [MEM_BW-1:0] s1_byte,
  input  logic [MEM_DW-1:0] s1_di,
  output logic [MEM_DW-1:0] s1_do,
  output logic              s1_busy,
  output logic              m_cs,
  output logic              m_we,
  output logic [MEM_AW-1:0] m_addr,
  output logic [MEM_BW-1:0] m_byte,
  output logic [MEM_DW-1:0] m_di,
  input  logic [MEM_DW-1:0] m_do,
  input  logic              m_busy
);

  localparam logic [7:0] BURST_CAP = 8'(MAX_BURST);

  mem_own_e   own_q;
  mem_own_e   rsp_q;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic       stall_q;   // previous cycle presented a request that m_busy stalled
  mem_own_e   grant;
  mem_own_e   rr_pick;
  logic       burst_done;
  logic       accept;

  rr_arb2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req0_i    (s0_cs),
    .req1_i    (s1_cs),
    .upd_i     (accept),
    .upd_own_i (grant),
    .pick_o    (rr_pick)
  );

  assign burst_done = (cnt_q >= BURST_CAP);

  // Grant: hold a stalled request, else keep the owner until its burst cap, else round-robin.
  // Nothing is granted while reset is asserted so the port stays idle.
  always_comb begin
    grant = rr_pick;
    if (rst) begin
      grant = OWN_NONE;
    end else if (own_q != OWN_NONE && stall_q) begin
      grant = own_q;
    end else if (own_q == OWN_S0 && s0_cs && !(burst_done && s1_cs)) begin
      grant = OWN_S0;
    end else if (own_q == OWN_S1 && s1_cs && !(burst_done && s0_cs)) begin
      grant = OWN_S1;
    end
  end

  // Downstream request mux; idle port drives all-zero fields
  always_comb begin
    m_cs   = 1'b0;
    m_we   = 1'b0;
    m_addr = '0;
    m_byte = '0;
    m_di   = '0;
    if (grant == OWN_S0) begin
      m_cs   = 1'b1;
      m_we   = s0_we;
      m_addr = s0_addr;
      m_byte = s0_byte;
      m_di   = s0_di;
    end else if (grant == OWN_S1) begin
      m_cs   = 1'b1;
      m_we   = s1_we;
      m_addr = s1_addr;
      m_byte = s1_byte;
      m_di   = s1_di;
    end
  end

  assign accept  = m_cs & ~m_busy;
  assign s0_busy = s0_cs & ((grant != OWN_S0) | m_busy);
  assign s1_busy = s1_cs & ((grant != OWN_S1) | m_busy);
  assign s0_do   = (rsp_q == OWN_S0) ? m_do : '0;
  assign s1_do   = (rsp_q == OWN_S1) ? m_do : '0;

  // Burst counter: restarts on an owner change, saturates at 255 while the owner keeps going
  always_comb begin
    cnt_d = cnt_q;
    if (grant != own_q) begin
      cnt_d = accept ? 8'd1 : 8'd0;
    end else if (accept && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Owner, burst count, stall flag and read-response owner
  always_ff @(posedge clk) begin
    if (rst) begin
      own_q   <= OWN_NONE;
      cnt_q   <= 8'd0;
      rsp_q   <= OWN_NONE;
      stall_q <= 1'b0;
    end else begin
      own_q   <= grant;
      cnt_q   <= cnt_d;
      rsp_q   <= (accept && !m_we) ? grant : OWN_NONE;
      stall_q <= m_cs & m_busy;
    end
  end

endmodule

// File: doc/mem_arb2.md
# mem_arb2

Two-requester arbiter for a single synchronous memory-interface port (cs/we/addr/byte/di/do/busy). It sits between two memory-style masters, such as instruction and data fetch paths or a DMA and a core, and one `axi2mem_bridge`-style memory master port or SRAM wrapper. Each cycle it grants the port to one requester, using round-robin with a per-grant burst cap. It returns read data only to the requester that issued the access.

## Interface
- `MAX_BURST`, default 4: maximum consecutive accepted transfers for one owner while the other requester waits; legal range 1–255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s0_cs`, `s1_cs`  in  1  request valid.
- `s0_we`, `s1_we`  in  1  write (1) / read (0).
- `s0_addr`, `s1_addr`  in  32  byte address.
- `s0_byte`, `s1_byte`  in  4  byte enables.
- `s0_di`, `s1_di`  in  32  write data.
- `s0_do`, `s1_do`  out  32  read data.
- `s0_busy`, `s1_busy`  out  1  stall; a request is accepted only in a cycle with cs=1, busy=0.
- `m_cs`, `m_we`, `m_addr` [32], `m_byte` [4], `m_di` [32]  out  downstream request, muxed from the granted requester.
- `m_do`  in  32  downstream read data.
- `m_busy`  in  1  downstream stall.

## Operation
- **State**
  - `own` ∈ {NONE, S0, S1}.
  - `last` is the round-robin pointer: the last requester served, 1 bit.
  - `cnt` is 8 bits.
  - `rsp` ∈ {NONE, S0, S1} is the owner of the read data due this cycle.
- **Grant `g` (combinational) from the registered state:**
  - **Hold rule:** if `own`≠NONE, `m_cs`=1 and `m_busy`=1 from the previous cycle, `g=own`. A stalled request is never withdrawn or switched.
  - **Keep rule:** else if `own`≠NONE, the owner's cs=1, and not (`cnt`≥`MAX_BURST` and the other cs=1), `g=own`.
  - **Switch rule:** else if exactly one cs=1, g is that requester. If both cs=1, g is the one that is not `last`. If neither, `g=NONE`.
- **Outputs**
  - `m_*` request fields come from g. If `g=NONE`: `m_cs=0`, `m_we=0`, and the other fields are 0.
  - `sX_busy` = `sX_cs` & (g≠X | `m_busy`).
  - `sX_do` = `m_do` when `rsp`=X, else 0.
- **Accept** = `m_cs` & !`m_busy`.
- **Register update**
  - `own` ← g.
  - `cnt`:
    - if g≠`own`, `cnt` ← accept ? 1 : 0;
    - else if accept, `cnt` ← min(`cnt`+1, 255).
  - `last` ← g on accept.
  - `rsp` ← g if accept and `m_we=0`, else NONE.
- **Reset values**
  - `own`=NONE, `cnt`=0, `last`=S1 (so S0 wins the first tie), `rsp`=NONE.
  - All outputs: `m_cs`=0, `m_*` fields 0, `sX_do`=0.
  - `sX_busy` equals `sX_cs` during and immediately after reset until granted.

## Timing
- **Grant latency:** zero cycles. A lone request on an idle port is presented to `m_*` in the same cycle.
- **Read data:** appears on `sX_do` exactly one cycle after the accept cycle. Writes produce no response.
- **Back-to-back accepts:** one per cycle for one owner, and also across an owner switch with no bubble.
- **Fairness:** with both requesting continuously, grants alternate in runs of `MAX_BURST` accepts. With `MAX_BURST`=1 they alternate every accept.
- **`m_busy` stall:** g, `m_*` and `cnt` are frozen for its duration. The stalled requester sees busy=1; the other sees busy=cs.
- **Owner drops cs mid-burst:** the grant moves to the other requester in that same cycle if it is requesting; `cnt` restarts.
- **Reset mid-transfer:** takes effect at the next edge. A pending `rsp` is discarded, so `sX_do`=0 next cycle.

## Structure
- Shared package `mem_intf_pkg`:
  - `typedef enum logic [1:0] {OWN_NONE, OWN_S0, OWN_S1} mem_own_e`;
  - `localparam MEM_AW=32, MEM_DW=32, MEM_BW=4`.
- A single module is sufficient. Optional sub-module `rr_arb2` holds the pointer and tie-break logic.

## Test plan
- **Lone request:** S0 reads 0x100 with `m_busy`=0 → `m_cs`=1 and `m_addr`=0x100 the same cycle. Memory `m_do`=0xDEADBEEF next cycle → `s0_do`=0xDEADBEEF, `s1_do`=0.
- **First tie after reset:** both requesters present a request every cycle, `MAX_BURST`=4 → S0 gets 4 accepts, then S1 gets 4, repeating. No idle cycle at any switch.
- **Stall freeze:** S1 writes with `m_busy`=1 for 3 cycles while S0 raises cs → `m_addr` stays at S1's address and `s0_busy`=1 for all 3 cycles. S0 is granted the cycle after S1's accept.
- **Owner drops mid-burst:** S0 drops cs after 2 accepts with S1 waiting → S1 is granted that same cycle. S1's first accept sets `cnt`=1.
- **Reset mid-read:** assert `rst` in the cycle after an S1 read accept → next cycle `s1_do`=0, `m_cs`=0, `own`=NONE. After release, a tie is won by S0.
- **Write response routing:** S0 writes, then S1 reads back to back → `rsp` is NONE for the write and S1 for the read. `s0_do` stays 0 throughout.
